// File: rtl/i2s_pkg.sv
// Shared I2S framing helpers: frame length, WS phase boundaries and slot padding.
// Used by both the transmit and receive paths.
package i2s_pkg;

    localparam int MAX_SLOT_W  = 64;
    localparam int DEF_SLOT_W  = 32;
    localparam int FRAME_BITS  = 2 * DEF_SLOT_W;
    localparam int WS_HI_FIRST = DEF_SLOT_W - 1;
    localparam int WS_HI_LAST  = 2 * DEF_SLOT_W - 2;

    function automatic int frame_bits(input int slot_w);
        return 2 * slot_w;
    endfunction

    // WS runs one bit ahead of the channel it selects.
    function automatic logic ws_level(input int b, input int slot_w);
        return (b >= slot_w - 1) && (b <= 2 * slot_w - 2);
    endfunction

    // Left-justify a sample inside its slot, zero-filling the LSBs.
    function automatic logic [MAX_SLOT_W-1:0] pad_slot(input logic [MAX_SLOT_W-1:0] data,
                                                       input int data_w,
                                                       input int slot_w);
        return data << (slot_w - data_w);
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// I2S bit-clock divider: sck toggles every CLK_DIV clks while enabled.
// fall_evt is a combinational strobe, high in the clk whose edge drives sck 1->0.
// enable low clears the divider and parks sck low.
module i2s_clkgen #(
    parameter int CLK_DIV = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic sck,
    output logic fall_evt
);

    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (!enable) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign fall_evt = enable && sck && (cnt == CNT_LAST);

endmodule

// File: rtl/i2s_tx.sv
// I2S (Philips) master transmitter: one-entry sample holding buffer feeding a frame shifter.
// ws/sd change on the clk that drives sck low; a pair waits at most one frame in the buffer.
// sample_ready is low while the buffer holds a pair; an empty buffer at frame load sends zeros.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int DATA_W  = 24,
    parameter int SLOT_W  = 32,
    parameter int CLK_DIV = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DATA_W-1:0] left_data,
    input  logic [DATA_W-1:0] right_data,
    input  logic              sample_valid,
    output logic              sample_ready,
    output logic              sck,
    output logic              ws,
    output logic              sd,
    output logic              frame_start,
    output logic              underrun
);

    localparam int FRAME = frame_bits(SLOT_W);
    localparam int BW    = (FRAME > 2) ? $clog2(FRAME) : 1;
    localparam logic [BW-1:0] B_LAST = BW'(FRAME - 1);

    logic              fall_evt;
    logic [BW-1:0]     b;
    logic [BW-1:0]     nb;
    logic [FRAME-1:0]  shift_q;
    logic [FRAME-1:0]  load_word;
    logic              hold_full;
    logic [DATA_W-1:0] hold_l;
    logic [DATA_W-1:0] hold_r;
    logic              load;
    logic              accept;
    logic [MAX_SLOT_W-1:0] l_pad;
    logic [MAX_SLOT_W-1:0] r_pad;

    i2s_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk      (clk),
        .reset    (reset),
        .enable   (enable),
        .sck      (sck),
        .fall_evt (fall_evt)
    );

    always_comb begin
        nb        = (b == B_LAST) ? '0 : b + 1'b1;
        load      = fall_evt && (nb == '0);
        accept    = sample_valid && !hold_full;
        l_pad     = pad_slot(MAX_SLOT_W'(hold_l), DATA_W, SLOT_W);
        r_pad     = pad_slot(MAX_SLOT_W'(hold_r), DATA_W, SLOT_W);
        load_word = hold_full ? {l_pad[SLOT_W-1:0], r_pad[SLOT_W-1:0]} : '0;
    end

    assign sample_ready = !hold_full;

    // Holding buffer runs independently of enable; a capture in a load clk waits a frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_full <= 1'b0;
            hold_l    <= '0;
            hold_r    <= '0;
        end else if (accept) begin
            hold_full <= 1'b1;
            hold_l    <= left_data;
            hold_r    <= right_data;
        end else if (load && enable) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b           <= B_LAST;
            shift_q     <= '0;
            ws          <= 1'b0;
            sd          <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else if (!enable) begin
            b           <= B_LAST;
            shift_q     <= '0;
            ws          <= 1'b0;
            sd          <= 1'b0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            if (fall_evt) begin
                b  <= nb;
                ws <= ws_level(int'(nb), SLOT_W);
                if (load) begin
                    shift_q     <= load_word;
                    sd          <= load_word[FRAME-1];
                    frame_start <= 1'b1;
                    underrun    <= !hold_full;
                end else begin
                    shift_q <= shift_q << 1;
                    sd      <= shift_q[FRAME-2];
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Randomized bench for i2s_tx with a time-based reference model (bit position derived from clk count).
module tb_i2s_tx;

    localparam int DW = 24;
    localparam int SW = 32;
    localparam int CD = 2;
    localparam int FB = 2 * SW;
    localparam int FRAME_CLKS = FB * 2 * CD;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [DW-1:0] left_data;
    logic [DW-1:0] right_data;
    logic          sample_valid;
    logic          sample_ready;
    logic          sck, ws, sd, frame_start, underrun;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    int          t;
    int          m_bit;
    logic        m_full;
    logic [DW-1:0] m_l, m_r;
    logic [FB-1:0] m_word;
    logic        m_sck, m_ws, m_sd, m_fs, m_ur;

    i2s_tx #(.DATA_W(DW), .SLOT_W(SW), .CLK_DIV(CD)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .left_data    (left_data),
        .right_data   (right_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .sck          (sck),
        .ws           (ws),
        .sd           (sd),
        .frame_start  (frame_start),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s t=%0d bit=%0d got=%h want=%h @%0t", tag, t, m_bit, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        t = 0; m_bit = FB - 1; m_full = 1'b0; m_l = '0; m_r = '0; m_word = '0;
        m_sck = 1'b0; m_ws = 1'b0; m_sd = 1'b0; m_fs = 1'b0; m_ur = 1'b0;
    endtask

    // Applied at each rising clk using the inputs held across that edge.
    task automatic model_update();
        logic acc;
        int   k;
        if (reset) begin
            model_reset();
            return;
        end
        m_fs = 1'b0; m_ur = 1'b0;
        acc  = sample_valid && !m_full;
        if (!enable) begin
            t = 0; m_bit = FB - 1; m_word = '0;
            m_sck = 1'b0; m_ws = 1'b0; m_sd = 1'b0;
        end else begin
            t++;
            m_sck = ((t / CD) % 2) == 1;
            if (t % (2 * CD) == 0) begin
                k = t / (2 * CD);
                m_bit = (k - 1) % FB;
                if (m_bit == 0) begin
                    m_fs = 1'b1;
                    if (m_full) begin
                        m_word = {m_l, 8'h00, m_r, 8'h00};
                        m_full = 1'b0;
                    end else begin
                        m_word = '0;
                        m_ur = 1'b1;
                    end
                end
                m_ws = (m_bit >= SW - 1) && (m_bit <= FB - 2);
                m_sd = m_word[FB-1-m_bit];
            end
        end
        if (acc) begin
            m_full = 1'b1; m_l = left_data; m_r = right_data;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk(tag, 64'({sck, ws, sd, frame_start, underrun, sample_ready}),
                 64'({m_sck, m_ws, m_sd, m_fs, m_ur, ~m_full}));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs("out");
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic offer(input logic [DW-1:0] l, input logic [DW-1:0] r);
        left_data = l; right_data = r; sample_valid = 1'b1;
    endtask

    initial begin
        bit found;
        reset = 1'b1; enable = 1'b0; sample_valid = 1'b0;
        left_data = '0; right_data = '0;
        model_reset();
        run(2);
        chk("reset_vals", 64'({sck, ws, sd, frame_start, underrun, sample_ready}), 64'b000001);
        reset = 1'b0;
        run(2);

        // Known pair loaded before the first fall.
        offer(24'hA5A5A5, 24'h123456);
        cycle();
        sample_valid = 1'b0;
        chk("ready_after_accept", 64'(sample_ready), 64'd0);
        enable = 1'b1;
        run(FRAME_CLKS + 8);

        // Starved for two frames.
        run(2 * FRAME_CLKS);

        // Continuous offering with fresh data every clk.
        for (int i = 0; i < 4 * FRAME_CLKS; i++) begin
            offer(DW'($urandom), DW'($urandom));
            cycle();
        end
        sample_valid = 1'b0;
        run(FRAME_CLKS);

        // Offer in the same clk as a load, buffer empty.
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLKS && !found; i++) begin
            if (t % FRAME_CLKS == 3 && !m_full) found = 1'b1;
            else cycle();
        end
        chk("wait_load_clk", 64'(found), 64'd1);
        offer(24'h5A5A5A, 24'hC3C3C3);
        cycle();
        sample_valid = 1'b0;
        chk("underrun_on_load", 64'(underrun), 64'd1);
        run(2 * FRAME_CLKS);

        // Drop enable at bit 40 while a pair is held.
        offer(24'h0F0F0F, 24'hF0F0F0);
        found = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLKS && !found; i++) begin
            cycle();
            sample_valid = sample_valid && !m_full ? 1'b1 : 1'b0;
            if (m_full && m_bit == 40) found = 1'b1;
        end
        sample_valid = 1'b0;
        chk("wait_bit40", 64'(found), 64'd1);
        enable = 1'b0;
        cycle();
        chk("disable_idle", 64'({sck, ws, sd}), 64'd0);
        run(15);
        chk("hold_kept", 64'(sample_ready), 64'd0);
        enable = 1'b1;
        run(2 * FRAME_CLKS);

        // Asynchronous reset between clk edges, mid-frame.
        offer(24'h111111, 24'h222222);
        run(300);
        sample_valid = 1'b0;
        @(posedge clk);
        model_update();
        #2 reset = 1'b1;
        #1 chk("async_reset", 64'({sck, ws, sd, frame_start, underrun, sample_ready}), 64'b000001);
        model_reset();
        @(negedge clk);
        run(3);
        reset = 1'b0;
        enable = 1'b0;
        cycle();
        offer(24'hA5A5A5, 24'h123456);
        cycle();
        sample_valid = 1'b0;
        enable = 1'b1;
        run(FRAME_CLKS + 8);

        // Random traffic with occasional enable gaps.
        for (int i = 0; i < 12000; i++) begin
            sample_valid = ($urandom_range(3) == 0);
            left_data    = DW'($urandom);
            right_data   = DW'($urandom);
            if ($urandom_range(1999) == 0) enable = ~enable;
            else if (!enable && $urandom_range(40) == 0) enable = 1'b1;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
